quad_enc: RTL and testbench
===========================

QUAD_ENC -- requirements
Module: quad_enc

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16: consecutive stable cycles needed before a synchronised input is accepted (range 2..65535).
REQ-002 SHALL have parameter POS_W, default 8: position counter width in bits.
REQ-003 SHALL have parameter STEPS_PER_DETENT, default 4: valid quadrature transitions per reported step (legal values 1, 2, 4).
REQ-004 SHALL have parameter WRAP, default 1: 1 = position wraps, 0 = position saturates.
REQ-005 SHALL have parameters POS_MIN, default 0, and POS_MAX, default 2**POS_W-1: unsigned position bounds, with POS_MIN < POS_MAX.
REQ-006 SHALL have parameter LONG_CYCLES, default 1024: held-press duration that qualifies as a long press.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have ports enc_a and enc_b, input, 1 bit each: raw quadrature inputs, asynchronous to clk.
REQ-010 SHALL have port enc_sw, input, 1 bit: raw push switch, active-low, asynchronous.
REQ-011 SHALL have port clr, input, 1 bit: synchronous position clear.
REQ-012 SHALL have port pos, output, POS_W bits: current position.
REQ-013 SHALL have port step, output, 1 bit: one-cycle pulse per detent.
REQ-014 SHALL have port dir, output, 1 bit: direction of the last step (1 = CW); holds its value between steps.
REQ-015 SHALL have ports sw_level, sw_press and sw_long, output, 1 bit each: sw_level = debounced pressed level; sw_press and sw_long are one-cycle pulses.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal quadrature transition.

Function
REQ-017 SHALL pass each raw input through a 2-flop synchroniser, followed by its own debounce counter.
REQ-018 Debounce SHALL operate as follows:
- any cycle where the synchronised value equals the debounced value clears the counter;
- otherwise the counter increments;
- on the cycle the counter reaches DB_CYCLES-1, the debounced value is loaded and the counter is cleared.
REQ-019 A raw change held stable SHALL appear on the debounced signal DB_CYCLES+2 edges after the first edge that samples the new raw value; step, pos, dir and err SHALL update on the next edge.
REQ-020 The decoder SHALL compare the previous and current debounced {a,b}:
- 00->10->11->01->00 counts +1;
- the reverse sequence counts -1;
- no change counts 0;
- a change of both bits pulses err, counts nothing, and loads the new state as previous.
REQ-021 A signed sub-counter SHALL accumulate the decoder counts:
- reaching +STEPS_PER_DETENT pulses step with dir=1 and clears the sub-counter;
- reaching -STEPS_PER_DETENT pulses step with dir=0 and clears the sub-counter;
- reversal mid-detent only moves the sub-counter and produces no step.
REQ-022 With WRAP=1, a CW step SHALL take POS_MAX to POS_MIN, and a CCW step SHALL take POS_MIN to POS_MAX.
REQ-023 With WRAP=0, pos SHALL hold at POS_MAX on CW and at POS_MIN on CCW; step and dir SHALL still pulse.
REQ-024 clr SHALL load pos=POS_MIN and clear the sub-counter; when a step coincides with clr, clr wins and the step pulse is suppressed.
REQ-025 sw_level SHALL equal the inverted debounced enc_sw.
REQ-026 sw_press SHALL pulse for one cycle on each debounced released->pressed edge; the release edge produces no pulse.
REQ-027 A hold counter SHALL operate as follows:
- increments while sw_level=1;
- saturates at LONG_CYCLES;
- clears when sw_level=0.
REQ-028 sw_long SHALL pulse exactly once per press, on the cycle the hold counter reaches LONG_CYCLES.
REQ-029 Encoder and switch paths SHALL be independent; simultaneous step and sw_press pulses are permitted.

Reset
REQ-030 On rst=1, the block SHALL asynchronously:
- set synchroniser and debounce registers for a, b and sw to 1;
- clear all counters;
- set pos=POS_MIN;
- set step, dir, err, sw_level, sw_press and sw_long to 0.
REQ-031 For the first DB_CYCLES+3 cycles after rst deasserts (startup blanking), the decoder SHALL copy the debounced state into previous with no counting and no err.
REQ-032 Asserting rst mid-detent or mid-press SHALL discard the partial state; no step, sw_press or sw_long pulse SHALL occur on or after the release of reset as a result of that partial state.

Verification
REQ-033 Bench SHALL cover defaults, after blanking, with one full CW cycle (11->01->00->10->11, each held 40 cycles) -> exactly one step, dir=1, pos 0->1.
REQ-034 Bench SHALL cover WRAP=1 with pos=0 and one CCW detent -> pos=255, dir=0; with WRAP=0 and the same stimulus -> pos stays 0 and step pulses once.
REQ-035 Bench SHALL cover a glitch on enc_a of DB_CYCLES-1 cycles -> no debounced change, no step, no err; a glitch of DB_CYCLES+2 cycles -> exactly one sub-count.
REQ-036 Bench SHALL cover a simultaneous 11->00 change of {a,b} held 40 cycles -> err pulses once, pos unchanged.
REQ-037 Bench SHALL cover enc_sw held low for 2000 cycles -> sw_press once about 18 cycles after the fall, sw_long once 1024 cycles after sw_level rises, and nothing on release.
REQ-038 Bench SHALL cover clr asserted on the same cycle a step would occur -> pos=POS_MIN, no step pulse; and rst asserted mid-detent -> pos=POS_MIN, with the next full detent producing exactly one step.

Source files
------------

// File: rtl/quad_enc.sv
// Quadrature rotary encoder front end with push switch.
// Raw inputs are synchronised and debounced. A transition decoder feeds a
// signed detent accumulator that drives a bounded position counter. The
// switch path produces a pressed level, a press pulse and a long-press pulse.
module quad_enc #(
  parameter int DB_CYCLES        = 16,
  parameter int POS_W            = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 1,
  parameter int POS_MIN          = 0,
  parameter int POS_MAX          = 2**POS_W-1,
  parameter int LONG_CYCLES      = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_sw,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             sw_level,
  output logic             sw_press,
  output logic             sw_long,
  output logic             err
);

  // ---------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------
  // Debounce counter only ever holds 0..DB_CYCLES-1.
  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Startup blanking covers the window in which a non-idle encoder state
  // still has to work its way through the synchroniser and debouncer.
  localparam int BLANK_CYCLES = DB_CYCLES + 3;
  localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);
  localparam logic [BLANK_W-1:0] BLANK_DONE = BLANK_W'(BLANK_CYCLES);

  // Sub-counter needs to reach +/-STEPS_PER_DETENT, plus a sign bit.
  localparam int SUB_W = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic signed [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic signed [SUB_W-1:0] SUB_POS  = SUB_W'(STEPS_PER_DETENT);
  localparam logic signed [SUB_W-1:0] SUB_NEG  = -SUB_POS;
  localparam logic signed [SUB_W-1:0] SUB_ZERO = '0;

  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);

  // Hold counter saturates at LONG_CYCLES.
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Input conditioning: one synchroniser + debouncer per raw input.
  // Bit 0 = b, bit 1 = a, bit 2 = switch (active-low raw).
  // ---------------------------------------------------------------------
  logic [2:0] raw_in;
  logic [2:0] db_bits;

  assign raw_in = {enc_sw, enc_a, enc_b};

  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    logic            meta_reg;
    logic            sync_reg;
    logic            db_reg;
    logic [DB_W-1:0] cnt_reg;

    // Two-flop synchroniser; idles high to match pulled-up inputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= raw_in[gi];
        sync_reg <= meta_reg;
      end
    end

    // Debounce: any agreeing cycle restarts the count; the new value is
    // accepted on the cycle after the counter has reached DB_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_reg  <= 1'b1;
        cnt_reg <= '0;
      end else if (sync_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_LAST) begin
        db_reg  <= sync_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign db_bits[gi] = db_reg;
  end

  logic [1:0] cur_ab;
  logic       db_sw;

  assign cur_ab = {db_bits[1], db_bits[0]};
  assign db_sw  = db_bits[2];

  // ---------------------------------------------------------------------
  // Startup blanking
  // ---------------------------------------------------------------------
  logic [BLANK_W-1:0] blank_cnt_reg;
  logic               blanking;

  assign blanking = (blank_cnt_reg != BLANK_DONE);

  // Count the first cycles out of reset, then park at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_cnt_reg <= '0;
    end else if (blanking) begin
      blank_cnt_reg <= blank_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Quadrature transition decoder
  // ---------------------------------------------------------------------
  logic [1:0] prev_ab_reg;
  logic       q_inc;
  logic       q_dec;
  logic       q_illegal;

  // Classify the previous->current debounced {a,b} pair.
  always_comb begin
    q_inc     = 1'b0;
    q_dec     = 1'b0;
    q_illegal = 1'b0;
    case ({prev_ab_reg, cur_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: q_inc     = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: q_dec     = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: q_illegal = 1'b1;
      default:                                ;
    endcase
  end

  // Previous state always follows the current one: after a legal move,
  // after an illegal jump, and during blanking alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_reg <= 2'b11;
    end else begin
      prev_ab_reg <= cur_ab;
    end
  end

  // ---------------------------------------------------------------------
  // Detent accumulator and position counter
  // ---------------------------------------------------------------------
  logic signed [SUB_W-1:0] sub_reg;
  logic signed [SUB_W-1:0] sub_next;
  logic signed [SUB_W-1:0] sub_sum;
  logic [POS_W-1:0]        pos_reg;
  logic [POS_W-1:0]        pos_next;
  logic                    step_reg;
  logic                    step_next;
  logic                    dir_reg;
  logic                    dir_next;
  logic                    err_reg;
  logic                    err_next;

  // Accumulate decoder counts, emit a step at a full detent, move pos
  // within bounds; clr overrides everything and swallows the step.
  always_comb begin
    sub_sum   = sub_reg;
    sub_next  = sub_reg;
    pos_next  = pos_reg;
    step_next = 1'b0;
    dir_next  = dir_reg;
    err_next  = 1'b0;

    if (q_inc) begin
      sub_sum = sub_reg + SUB_ONE;
    end else if (q_dec) begin
      sub_sum = sub_reg - SUB_ONE;
    end

    if (!blanking) begin
      err_next = q_illegal;
      if (sub_sum == SUB_POS) begin
        sub_next  = SUB_ZERO;
        step_next = 1'b1;
        dir_next  = 1'b1;
        if (pos_reg == P_MAX) begin
          pos_next = (WRAP != 0) ? P_MIN : P_MAX;
        end else begin
          pos_next = pos_reg + 1'b1;
        end
      end else if (sub_sum == SUB_NEG) begin
        sub_next  = SUB_ZERO;
        step_next = 1'b1;
        dir_next  = 1'b0;
        if (pos_reg == P_MIN) begin
          pos_next = (WRAP != 0) ? P_MAX : P_MIN;
        end else begin
          pos_next = pos_reg - 1'b1;
        end
      end else begin
        sub_next = sub_sum;
      end
    end

    if (clr) begin
      pos_next  = P_MIN;
      sub_next  = SUB_ZERO;
      step_next = 1'b0;
      dir_next  = dir_reg;
    end
  end

  // Encoder-side state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg  <= SUB_ZERO;
      pos_reg  <= P_MIN;
      step_reg <= 1'b0;
      dir_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      sub_reg  <= sub_next;
      pos_reg  <= pos_next;
      step_reg <= step_next;
      dir_reg  <= dir_next;
      err_reg  <= err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Push switch: level, press pulse, long-press pulse
  // ---------------------------------------------------------------------
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              sw_press_reg;
  logic              sw_long_reg;

  assign sw_level = ~db_sw;

  // Hold counter runs while pressed, saturates, clears on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_reg <= '0;
    end else if (!sw_level) begin
      hold_cnt_reg <= '0;
    end else if (hold_cnt_reg != HOLD_MAX) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

  // A pressed level with a zero hold count is the first pressed cycle;
  // the long pulse fires on the same edge the counter hits its ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_press_reg <= 1'b0;
      sw_long_reg  <= 1'b0;
    end else begin
      sw_press_reg <= sw_level && (hold_cnt_reg == '0);
      sw_long_reg  <= sw_level && (hold_cnt_reg == HOLD_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign pos      = pos_reg;
  assign step     = step_reg;
  assign dir      = dir_reg;
  assign err      = err_reg;
  assign sw_press = sw_press_reg;
  assign sw_long  = sw_long_reg;

endmodule

// File: tb/tb_quad_enc.sv
// Directed bench for quad_enc: a table of encoder phases with hand-computed
// results, followed by hand-written glitch, clr, reset and switch sequences.
module tb_quad_enc;

  localparam int DB    = 16;
  localparam int BLANK = DB + 3;
  localparam int NVEC  = 22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b1;
  logic       enc_b = 1'b1;
  logic       enc_sw = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] pos, s_pos;
  logic       step, dir, sw_level, sw_press, sw_long, err;
  logic       s_step, s_dir, s_sw_level, s_sw_press, s_sw_long, s_err;

  quad_enc dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .clr(clr), .pos(pos), .step(step), .dir(dir), .sw_level(sw_level),
    .sw_press(sw_press), .sw_long(sw_long), .err(err)
  );

  quad_enc #(.WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .clr(clr), .pos(s_pos), .step(s_step), .dir(s_dir), .sw_level(s_sw_level),
    .sw_press(s_sw_press), .sw_long(s_sw_long), .err(s_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled on the falling edge.
  int   step_cnt = 0, err_cnt = 0, press_cnt = 0, long_cnt = 0, sat_step_cnt = 0;
  int   press_cyc = 0, level_cyc = 0, long_cyc = 0;
  logic level_d = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (step) step_cnt++;
      if (s_step) sat_step_cnt++;
      if (err) err_cnt++;
      if (sw_press) begin press_cnt++; press_cyc = cyc; end
      if (sw_long) begin long_cnt++; long_cyc = cyc; end
      if (sw_level && !level_d) level_cyc = cyc;
    end
    level_d = sw_level;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic drive(input logic a, input logic b, input int n);
    enc_a = a;
    enc_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a;
    logic b;
    int   steps;
    int   errs;
    int   pos;
    logic dir;
    int   sat_pos;
  } vec_t;

  vec_t vecs[NVEC];
  int   s0, e0, ss0, p0, l0, fall_cyc;

  initial begin
    // {a, b, steps, errs, pos, dir, sat_pos}: each phase held 40 cycles.
    vecs[0]  = '{1'b0, 1'b1, 0, 0,   0, 1'b0, 0};  // CW detent from 11
    vecs[1]  = '{1'b0, 1'b0, 0, 0,   0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 0, 0,   0, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1, 0,   1, 1'b1, 1};
    vecs[4]  = '{1'b1, 1'b0, 0, 0,   1, 1'b1, 1};  // CCW detent back to 0
    vecs[5]  = '{1'b0, 1'b0, 0, 0,   1, 1'b1, 1};
    vecs[6]  = '{1'b0, 1'b1, 0, 0,   1, 1'b1, 1};
    vecs[7]  = '{1'b1, 1'b1, 1, 0,   0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b0, 0, 0,   0, 1'b0, 0};  // CCW at 0: wrap / hold
    vecs[9]  = '{1'b0, 1'b0, 0, 0,   0, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b1, 0, 0,   0, 1'b0, 0};
    vecs[11] = '{1'b1, 1'b1, 1, 0, 255, 1'b0, 0};
    vecs[12] = '{1'b0, 1'b1, 0, 0, 255, 1'b0, 0};  // CW at 255: wrap to 0
    vecs[13] = '{1'b0, 1'b0, 0, 0, 255, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 0, 0, 255, 1'b0, 0};
    vecs[15] = '{1'b1, 1'b1, 1, 0,   0, 1'b1, 1};
    vecs[16] = '{1'b0, 1'b1, 0, 0,   0, 1'b1, 1};  // reversal mid-detent
    vecs[17] = '{1'b0, 1'b0, 0, 0,   0, 1'b1, 1};
    vecs[18] = '{1'b0, 1'b1, 0, 0,   0, 1'b1, 1};
    vecs[19] = '{1'b1, 1'b1, 0, 0,   0, 1'b1, 1};
    vecs[20] = '{1'b0, 1'b0, 0, 1,   0, 1'b1, 1};  // illegal 11->00
    vecs[21] = '{1'b1, 1'b1, 0, 1,   0, 1'b1, 1};  // illegal 00->11

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst pos", int'(pos), 0);
    chk("rst step", int'(step), 0);
    chk("rst dir", int'(dir), 0);
    chk("rst err", int'(err), 0);
    chk("rst sw_level", int'(sw_level), 0);
    chk("rst sw_press", int'(sw_press), 0);
    chk("rst sw_long", int'(sw_long), 0);
    rst = 1'b0;
    repeat (BLANK + 5) @(posedge clk);
    #1;
    chk("blank steps", step_cnt, 0);
    chk("blank errs", err_cnt, 0);
    $display("reset released, pos=%0d", pos);

    // Table-driven encoder phases
    for (int i = 0; i < NVEC; i++) begin
      s0  = step_cnt;
      e0  = err_cnt;
      ss0 = sat_step_cnt;
      drive(vecs[i].a, vecs[i].b, 40);
      $display("vec %0d ab=%b%b pos=%0d dir=%0d steps=%0d errs=%0d sat_pos=%0d",
               i, vecs[i].a, vecs[i].b, pos, dir, step_cnt - s0, err_cnt - e0, s_pos);
      chk($sformatf("vec%0d steps", i), step_cnt - s0, vecs[i].steps);
      chk($sformatf("vec%0d errs", i), err_cnt - e0, vecs[i].errs);
      chk($sformatf("vec%0d pos", i), int'(pos), vecs[i].pos);
      chk($sformatf("vec%0d dir", i), int'(dir), int'(vecs[i].dir));
      chk($sformatf("vec%0d sat_pos", i), int'(s_pos), vecs[i].sat_pos);
      chk($sformatf("vec%0d sat_steps", i), sat_step_cnt - ss0, vecs[i].steps);
    end

    // Short glitch on a at sub=-3: DB-1 cycles must be ignored entirely.
    drive(1'b1, 1'b0, 40);
    drive(1'b0, 1'b0, 40);
    drive(1'b0, 1'b1, 40);
    s0 = step_cnt;
    e0 = err_cnt;
    drive(1'b1, 1'b1, DB - 1);
    drive(1'b0, 1'b1, 40);
    $display("short glitch: steps=%0d errs=%0d pos=%0d", step_cnt - s0, err_cnt - e0, pos);
    chk("short glitch steps", step_cnt - s0, 0);
    chk("short glitch errs", err_cnt - e0, 0);
    drive(1'b1, 1'b1, 40);
    chk("short glitch finish steps", step_cnt - s0, 1);
    chk("short glitch finish pos", int'(pos), 255);

    // Long glitch at sub=-3: DB+2 cycles supplies the one missing count.
    drive(1'b1, 1'b0, 40);
    drive(1'b0, 1'b0, 40);
    drive(1'b0, 1'b1, 40);
    s0 = step_cnt;
    e0 = err_cnt;
    drive(1'b1, 1'b1, DB + 2);
    drive(1'b0, 1'b1, 40);
    $display("long glitch: steps=%0d errs=%0d pos=%0d", step_cnt - s0, err_cnt - e0, pos);
    chk("long glitch steps", step_cnt - s0, 1);
    chk("long glitch errs", err_cnt - e0, 0);
    chk("long glitch dir", int'(dir), 0);
    chk("long glitch pos", int'(pos), 254);
    drive(1'b1, 1'b1, 40);
    chk("long glitch settle steps", step_cnt - s0, 1);
    chk("long glitch settle pos", int'(pos), 254);

    // clr on the exact edge the completing step would register.
    drive(1'b0, 1'b1, 40);
    drive(1'b0, 1'b0, 40);
    drive(1'b1, 1'b0, 40);
    s0 = step_cnt;
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (DB + 2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    $display("clr vs step: steps=%0d pos=%0d", step_cnt - s0, pos);
    chk("clr step suppressed", step_cnt - s0, 0);
    chk("clr pos", int'(pos), 0);
    drive(1'b0, 1'b1, 40);
    drive(1'b0, 1'b0, 40);
    drive(1'b1, 1'b0, 40);
    drive(1'b1, 1'b1, 40);
    chk("after clr steps", step_cnt - s0, 1);
    chk("after clr pos", int'(pos), 1);
    chk("after clr dir", int'(dir), 1);

    // Reset mid-detent (sub=+2, resting at 00).
    drive(1'b0, 1'b1, 40);
    drive(1'b0, 1'b0, 40);
    s0 = step_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid rst pos", int'(pos), 0);
    chk("mid rst step", int'(step), 0);
    rst = 1'b0;
    repeat (BLANK + 20) @(posedge clk);
    #1;
    $display("mid-detent reset: steps=%0d errs=%0d pos=%0d", step_cnt - s0, err_cnt - e0, pos);
    chk("post rst steps", step_cnt - s0, 0);
    chk("post rst errs", err_cnt - e0, 0);
    chk("post rst pos", int'(pos), 0);
    drive(1'b1, 1'b0, 40);
    drive(1'b1, 1'b1, 40);
    drive(1'b0, 1'b1, 40);
    drive(1'b0, 1'b0, 40);
    chk("post rst detent steps", step_cnt - s0, 1);
    chk("post rst detent pos", int'(pos), 1);
    chk("post rst detent dir", int'(dir), 1);

    // Switch held for 2000 cycles, then released.
    p0 = press_cnt;
    l0 = long_cnt;
    enc_sw = 1'b0;
    fall_cyc = cyc;
    repeat (2000) @(posedge clk);
    #1;
    $display("switch hold: press=%0d long=%0d level_at=%0d press_at=%0d long_at=%0d",
             press_cnt - p0, long_cnt - l0, level_cyc - fall_cyc,
             press_cyc - fall_cyc, long_cyc - fall_cyc);
    chk("sw level held", int'(sw_level), 1);
    chk("sw press count", press_cnt - p0, 1);
    chk("sw level latency", level_cyc - fall_cyc, DB + 2);
    chk("sw press latency", press_cyc - fall_cyc, DB + 3);
    chk("sw long count", long_cnt - l0, 1);
    chk("sw long delay", long_cyc - level_cyc, 1024);
    enc_sw = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    $display("switch release: level=%0d press=%0d long=%0d", sw_level, press_cnt - p0, long_cnt - l0);
    chk("sw released level", int'(sw_level), 0);
    chk("sw release press", press_cnt - p0, 1);
    chk("sw release long", long_cnt - l0, 1);

    // Reset mid-press: the interrupted hold must never yield a long pulse.
    p0 = press_cnt;
    l0 = long_cnt;
    enc_sw = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("mid press pressed", press_cnt - p0, 1);
    rst = 1'b1;
    enc_sw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (1200) @(posedge clk);
    #1;
    $display("mid-press reset: press=%0d long=%0d level=%0d", press_cnt - p0, long_cnt - l0, sw_level);
    chk("mid press rst press", press_cnt - p0, 1);
    chk("mid press rst long", long_cnt - l0, 0);
    chk("mid press rst level", int'(sw_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
